// File: rtl/conv_datapath_l3_pkg.sv
// Shared types and width helpers for the layer-3 convolution datapath.
package conv_l3_pkg;

  typedef enum logic [2:0] {
    LOAD_KER,
    FILL,
    MAC,
    OUT,
    SHIFT,
    DONE
  } conv_state_e;

  // Accumulator wide enough for TAPS full-scale signed products.
  function automatic int acc_w(input int dataW, input int taps);
    return 2 * dataW + $clog2(taps);
  endfunction

  function automatic int filt_w(input int filt);
    return (filt > 1) ? $clog2(filt) : 1;
  endfunction

endpackage

// File: rtl/conv_datapath_l3_if.sv
// Kernel, pixel and result streams of conv_datapath_l3, plus status flags.
interface conv_datapath_l3_if #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4,
  parameter int FILT   = 2
);
  import conv_l3_pkg::*;

  localparam int ACC_W = acc_w(DATA_W, TAPS);
  localparam int FW    = filt_w(FILT);

  logic signed [DATA_W-1:0] ker_in;
  logic                     ker_valid;
  logic                     ker_ready;
  logic signed [DATA_W-1:0] img_in;
  logic                     img_valid;
  logic                     img_last;
  logic                     img_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [FW-1:0]            out_filt;
  logic                     out_valid;
  logic                     out_ready;
  logic                     ker_loaded;
  logic                     done;

  modport slave (
    input  ker_in, ker_valid, img_in, img_valid, img_last, out_ready,
    output ker_ready, img_ready, out_data, out_filt, out_valid, ker_loaded, done
  );

  modport master (
    output ker_in, ker_valid, img_in, img_valid, img_last, out_ready,
    input  ker_ready, img_ready, out_data, out_filt, out_valid, ker_loaded, done
  );

endinterface

// File: rtl/conv_datapath_l3_mac.sv
// Sequential single-multiplier signed MAC: walks taps 0..TAPS-1 while enabled,
// loading the accumulator on tap 0 and adding on the rest.
module mac_unit_l3
  import conv_l3_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  TAPS   = 4,
  localparam int ACC_W  = acc_w(DATA_W, TAPS),
  localparam int TW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  output logic [TW-1:0]            tap,
  output logic                     lastTap,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prodExt;

  assign prod    = pixel * weight;
  assign prodExt = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  assign lastTap = (tap == TW'(TAPS - 1));

  // The tap counter wraps to 0 by itself so the next filter starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap <= '0;
      acc <= '0;
    end else if (en) begin
      tap <= lastTap ? '0 : tap + 1'b1;
      acc <= (tap == '0) ? prodExt : acc + prodExt;
    end
  end

endmodule

// File: rtl/conv_datapath_l3.sv
// 1-D multi-filter convolution datapath with valid/ready streams.
// Build option CONV_RELU_EN clamps negative results to zero at the output.
module conv_datapath_l3
  import conv_l3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4,
  parameter int FILT   = 2,
  parameter int STRIDE = 1
) (
  input logic               clk,
  input logic               rst,
  conv_datapath_l3_if.slave bus
);

  localparam int ACC_W = acc_w(DATA_W, TAPS);
  localparam int FW    = filt_w(FILT);
  localparam int TW    = $clog2(TAPS);
  localparam int CW    = $clog2(TAPS + 1);

  conv_state_e stateReg;
  logic [TW-1:0] kerTapReg;
  logic [FW-1:0] filtReg;
  logic [CW-1:0] countReg;
  logic          lastReg;
  logic          outValidReg;
  logic          doneReg;
  logic          kerLoadedReg;

  logic [TAPS-1:0][DATA_W-1:0] windowReg;
  logic [TAPS-1:0][DATA_W-1:0] kerBank [FILT];

  logic                    kerHs;
  logic                    imgHs;
  logic                    macEn;
  logic [TW-1:0]           macTap;
  logic                    macLastTap;
  logic signed [ACC_W-1:0] macAcc;

  assign kerHs = bus.ker_valid && (stateReg == LOAD_KER);
  assign imgHs = bus.img_valid && (stateReg == FILL);
  assign macEn = (stateReg == MAC);

  // One register bank per filter; weights arrive filter-major, tap-minor.
  for (genvar gi = 0; gi < FILT; gi++) begin : gBank
    logic [TAPS-1:0][DATA_W-1:0] bankReg;
    always_ff @(posedge clk) begin
      if (rst) begin
        bankReg <= '0;
      end else if (kerHs && (filtReg == FW'(gi))) begin
        bankReg[kerTapReg] <= bus.ker_in;
      end
    end
    assign kerBank[gi] = bankReg;
  end

  // Newest pixel enters at the top so tap 0 always holds the oldest one.
  always_ff @(posedge clk) begin
    if (rst) begin
      windowReg <= '0;
    end else if (imgHs) begin
      windowReg <= {bus.img_in, windowReg[TAPS-1:1]};
    end
  end

  mac_unit_l3 #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) uMac (
    .clk     (clk),
    .rst     (rst),
    .en      (macEn),
    .pixel   ($signed(windowReg[macTap])),
    .weight  ($signed(kerBank[filtReg][macTap])),
    .tap     (macTap),
    .lastTap (macLastTap),
    .acc     (macAcc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= LOAD_KER;
      kerTapReg    <= '0;
      filtReg      <= '0;
      countReg     <= '0;
      lastReg      <= 1'b0;
      outValidReg  <= 1'b0;
      doneReg      <= 1'b0;
      kerLoadedReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        LOAD_KER: begin
          if (bus.ker_valid) begin
            if (kerTapReg == TW'(TAPS - 1)) begin
              kerTapReg <= '0;
              if (filtReg == FW'(FILT - 1)) begin
                filtReg      <= '0;
                kerLoadedReg <= 1'b1;
                stateReg     <= FILL;
              end else begin
                filtReg <= filtReg + 1'b1;
              end
            end else begin
              kerTapReg <= kerTapReg + 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.img_valid) begin
            lastReg <= bus.img_last;
            if (countReg == CW'(TAPS - 1)) begin
              countReg <= CW'(TAPS);
              filtReg  <= '0;
              stateReg <= MAC;
            end else if (bus.img_last) begin
              // Stream ended mid-window: drop the partial window.
              countReg <= '0;
              doneReg  <= 1'b1;
              stateReg <= DONE;
            end else begin
              countReg <= countReg + 1'b1;
            end
          end
        end
        MAC: begin
          if (macLastTap) begin
            outValidReg <= 1'b1;
            stateReg    <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            outValidReg <= 1'b0;
            if (filtReg != FW'(FILT - 1)) begin
              filtReg  <= filtReg + 1'b1;
              stateReg <= MAC;
            end else if (lastReg) begin
              doneReg  <= 1'b1;
              stateReg <= DONE;
            end else begin
              stateReg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          countReg <= CW'(TAPS - STRIDE);
          stateReg <= FILL;
        end
        DONE: begin
          countReg <= '0;
          lastReg  <= 1'b0;
          stateReg <= FILL;
        end
        default: stateReg <= LOAD_KER;
      endcase
    end
  end

  assign bus.ker_ready  = (stateReg == LOAD_KER);
  assign bus.img_ready  = (stateReg == FILL);
  assign bus.out_valid  = outValidReg;
  assign bus.out_filt   = filtReg;
  assign bus.done       = doneReg;
  assign bus.ker_loaded = kerLoadedReg;

`ifdef CONV_RELU_EN
  assign bus.out_data = macAcc[ACC_W-1] ? '0 : macAcc;
`else
  assign bus.out_data = macAcc;
`endif

endmodule

// File: tb/tb_conv_datapath_l3.sv
// Randomised and directed bench for conv_datapath_l3 against a window-sum model.
module tb_conv_datapath_l3;
  import conv_l3_pkg::*;

  localparam int DATA_W = 8;
  localparam int TAPS   = 4;
  localparam int FILT   = 2;
`ifdef CONV_RELU_EN
  localparam longint NEG2 = 0;
`else
  localparam longint NEG2 = -2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_datapath_l3_if #(.DATA_W(DATA_W), .TAPS(TAPS), .FILT(FILT)) bus ();
  conv_datapath_l3_if #(.DATA_W(DATA_W), .TAPS(TAPS), .FILT(FILT)) bus2 ();

  conv_datapath_l3 #(.DATA_W(DATA_W), .TAPS(TAPS), .FILT(FILT), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  conv_datapath_l3 #(.DATA_W(DATA_W), .TAPS(TAPS), .FILT(FILT), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    bit     isDone;
    int     filt;
    longint data;
  } exp_t;

  exp_t   expq[$];
  int     kerM[FILT][TAPS];
  int     pixM[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  bit     forceLow = 0;
  bit     randReady = 0;
  bit     needDone = 0;
  int     got2f[$];
  longint got2d[$];
  int     done2 = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Every complete window of the stream, each filter in turn, then the done marker.
  function automatic void modelPush(input int stride);
    exp_t e;
    for (int s = 0; s + TAPS <= pixM.size(); s += stride) begin
      for (int f = 0; f < FILT; f++) begin
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(pixM[s+k]) * longint'(kerM[f][k]);
        e.isDone = 0;
        e.filt   = f;
        e.data   = relu(acc);
        expq.push_back(e);
      end
    end
    e.isDone = 1;
    e.filt   = 0;
    e.data   = 0;
    expq.push_back(e);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = forceLow ? 1'b0 : (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Compare process: outputs and done pulses against the model queue.
  initial forever begin
    @(negedge clk);
    if (bus.done) begin
      check("done_expected", (expq.size() > 0 && expq[0].isDone) ? 1 : 0, 1);
      if (expq.size() > 0 && expq[0].isDone) void'(expq.pop_front());
    end else if (needDone) begin
      check("done_timing", 0, 1);
    end
    if (bus.out_valid) begin
      if (expq.size() == 0 || expq[0].isDone) begin
        check("out_unexpected", 1, 0);
      end else begin
        check("out_filt", longint'(bus.out_filt), longint'(expq[0].filt));
        check("out_data", longint'($signed(bus.out_data)), expq[0].data);
        if (bus.out_ready) begin
          $display("out filt=%0d data=%0d", bus.out_filt, $signed(bus.out_data));
          void'(expq.pop_front());
        end
      end
    end
    needDone = ((bus.out_valid && bus.out_ready) || (bus.img_valid && bus.img_ready && bus.img_last))
               && expq.size() > 0 && expq[0].isDone;
  end

  initial forever begin
    @(negedge clk);
    if (bus2.out_valid && bus2.out_ready) begin
      got2f.push_back(int'(bus2.out_filt));
      got2d.push_back(longint'($signed(bus2.out_data)));
      $display("stride2 out filt=%0d data=%0d", bus2.out_filt, $signed(bus2.out_data));
    end
    if (bus2.done) done2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic sendKer(input int v);
    int n = 0;
    bus.ker_in    = DATA_W'(v);
    bus.ker_valid = 1'b1;
    @(negedge clk);
    while (!bus.ker_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("ker_timeout", 0, 1);
    tick();
    bus.ker_valid = 1'b0;
  endtask

  task automatic sendPix(input int v, input bit last, input int gapMax, output int hsCyc);
    int n = 0;
    repeat ($urandom_range(0, gapMax)) tick();
    bus.img_in    = DATA_W'(v);
    bus.img_last  = last;
    bus.img_valid = 1'b1;
    @(negedge clk);
    while (!bus.img_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("pix_timeout", 0, 1);
    hsCyc = cyc;
    tick();
    bus.img_valid = 1'b0;
    bus.img_last  = 1'b0;
  endtask

  task automatic loadKernels();
    for (int f = 0; f < FILT; f++)
      for (int t = 0; t < TAPS; t++) sendKer(kerM[f][t]);
  endtask

  task automatic runStream(input int gapMax);
    int hc;
    for (int i = 0; i < pixM.size(); i++) sendPix(pixM[i], i == pixM.size() - 1, gapMax, hc);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    check("drain_timeout", expq.size(), 0);
    expq.delete();
  endtask

  task automatic drive2(input bit isKer, input int v, input bit last);
    int n = 0;
    if (isKer) begin
      bus2.ker_in    = DATA_W'(v);
      bus2.ker_valid = 1'b1;
    end else begin
      bus2.img_in    = DATA_W'(v);
      bus2.img_last  = last;
      bus2.img_valid = 1'b1;
    end
    @(negedge clk);
    while (!(isKer ? bus2.ker_ready : bus2.img_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("stride2_timeout", 0, 1);
    tick();
    bus2.ker_valid = 1'b0;
    bus2.img_valid = 1'b0;
    bus2.img_last  = 1'b0;
  endtask

  initial begin
    int hc;
    int n;
    longint e2d[4] = '{10, 1, 18, 3};
    int     e2f[4] = '{0, 1, 0, 1};

    bus.ker_in = '0;  bus.ker_valid = 0;  bus.img_in = '0;  bus.img_valid = 0;  bus.img_last = 0;
    bus2.ker_in = '0; bus2.ker_valid = 0; bus2.img_in = '0; bus2.img_valid = 0; bus2.img_last = 0;
    bus2.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_filt", longint'(bus.out_filt), 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_ker_loaded", bus.ker_loaded, 0);
    check("rst_ker_ready", bus.ker_ready, 1);
    check("rst_img_ready", bus.img_ready, 0);
    tick();
    rst = 1'b0;

    // Reference scenario with backpressure on the first result
    kerM = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}};
    loadKernels();
    check("ker_loaded", bus.ker_loaded, 1);
    check("ker_ready_after_load", bus.ker_ready, 0);
    pixM = '{1, 2, 3, 4, 5};
    modelPush(1);
    check("pin_w0_f0", expq[0].data, 10);
    check("pin_w0_f1", expq[1].data, NEG2);
    check("pin_w1_f0", expq[2].data, 14);
    check("pin_w1_f1", expq[3].data, NEG2);
    check("pin_done", expq[4].isDone, 1);
    forceLow = 1;
    for (int i = 0; i < 4; i++) sendPix(pixM[i], 0, 0, hc);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    check("latency", cyc - hc, TAPS + 1);
    repeat (5) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_img_ready", bus.img_ready, 0);
      tick();
    end
    forceLow = 0;
    sendPix(5, 1, 0, hc);
    waitIdle();

    // Reset during tap 2 of a MAC
    for (int i = 0; i < 4; i++) sendPix(9, 0, 0, hc);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_out_data", longint'(bus.out_data), 0);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_out_filt", longint'(bus.out_filt), 0);
    check("mid_ker_loaded", bus.ker_loaded, 0);
    check("mid_done", bus.done, 0);
    check("mid_ker_ready", bus.ker_ready, 1);
    check("mid_img_ready", bus.img_ready, 0);
    bus.img_in    = 8'sd7;
    bus.img_valid = 1'b1;
    repeat (3) begin
      check("noker_img_ready", bus.img_ready, 0);
      tick();
    end
    bus.img_valid = 1'b0;

    // Full-scale negative operands
    for (int f = 0; f < FILT; f++)
      for (int t = 0; t < TAPS; t++) kerM[f][t] = -128;
    loadKernels();
    pixM = '{-128, -128, -128, -128};
    modelPush(1);
    check("pin_extreme", expq[0].data, 65536);
    runStream(0);
    waitIdle();

    // Stream shorter than one window
    pixM = '{3, 1, 2};
    modelPush(1);
    check("pin_short", expq.size(), 1);
    runStream(2);
    waitIdle();

    // Random kernels, streams, gaps and backpressure
    randReady = 1;
    for (int ks = 0; ks < 2; ks++) begin
      doReset();
      for (int f = 0; f < FILT; f++)
        for (int t = 0; t < TAPS; t++) kerM[f][t] = int'($urandom_range(0, 255)) - 128;
      loadKernels();
      for (int s = 0; s < 6; s++) begin
        pixM.delete();
        repeat ($urandom_range(1, 10)) pixM.push_back(int'($urandom_range(0, 255)) - 128);
        modelPush(1);
        runStream(3);
      end
      waitIdle();
    end
    randReady = 0;

    // STRIDE=2 instance
    doReset();
    for (int t = 0; t < TAPS; t++) drive2(1, 1, 0);
    for (int t = 0; t < TAPS; t++) drive2(1, (t == 0) ? 1 : 0, 0);
    for (int p = 1; p <= 6; p++) drive2(0, p, p == 6);
    n = 0;
    while (done2 == 0 && n < 100) begin
      tick();
      n++;
    end
    check("stride2_done", done2, 1);
    check("stride2_count", got2d.size(), 4);
    for (int i = 0; i < 4 && i < got2d.size(); i++) begin
      check("stride2_filt", got2f[i], e2f[i]);
      check("stride2_data", got2d[i], e2d[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
